serial_secded_receiver: RTL and testbench

Parametrised serial frame receiver, the successor to the fixed 8-bit Receiver. It hunts a configurable sync pattern on a one-bit serial line and collects a fixed number of Hamming SECDED codewords. Each codeword is corrected or flagged, and the block presents one data word per codeword. It sits between the serial link and the message-consuming logic, and also keeps saturating error statistics for link-quality monitoring.

---
 rtl/serial_secded_receiver_if.sv | 30 +++
 rtl/serial_secded_receiver.sv | 158 +++++++++++++++
 tb/tb_serial_secded_receiver.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_secded_receiver_if.sv
// rtl/serial_secded_receiver_if.sv - serial line in / decoded message out bundle for serial_secded_receiver
//
// Signals:
//   serialIn      serial data, one bit sampled per clock
//   messageWord   last decoded (corrected) data word
//   isNew         one-cycle pulse: messageWord just updated
//   corrected     qualifies isNew: single-bit error was corrected
//   uncorrectable qualifies isNew: double-bit error detected
//   inFrame       high while the receiver is collecting codewords
// Modports: master = receiver side, slave = link driver / message consumer side.
interface serial_secded_receiver_if #(
    parameter int DATA_W = 8
);
    logic              serialIn;
    logic [DATA_W-1:0] messageWord;
    logic              isNew;
    logic              corrected;
    logic              uncorrectable;
    logic              inFrame;

    modport master (
        input  serialIn,
        output messageWord, isNew, corrected, uncorrectable, inFrame
    );

    modport slave (
        output serialIn,
        input  messageWord, isNew, corrected, uncorrectable, inFrame
    );
endinterface

// File: rtl/serial_secded_receiver.sv
// rtl/serial_secded_receiver.sv - sync-hunting serial receiver with Hamming SECDED decode and error statistics
//
// Ports:
//   clock      sole clock, all state updates on posedge
//   reset_L    asynchronous active-low reset
//   rx         serial_secded_receiver_if.master (serialIn in; messageWord/isNew/flags/inFrame out)
//   corrCount  saturating count of corrected words
//   dueCount   saturating count of uncorrectable words
module serial_secded_receiver #(
    parameter int                DATA_W          = 8,
    parameter int                SYNC_W          = 8,
    parameter logic [SYNC_W-1:0] SYNC_PATTERN    = 'h7E,
    parameter int                WORDS_PER_FRAME = 4,
    parameter bit                ABORT_ON_DUE    = 1'b0,
    parameter int                CNT_W           = 8
) (
    input  logic                       clock,
    input  logic                       reset_L,
    serial_secded_receiver_if.master   rx,
    output logic [CNT_W-1:0]           corrCount,
    output logic [CNT_W-1:0]           dueCount
);
    // Smallest P with 2^P >= DATA_W+P+1; scanning downwards keeps the smallest hit.
    function automatic int calcParityBits(input int dw);
        int p;
        p = 0;
        for (int k = 7; k >= 1; k--) begin
            if ((1 << k) >= dw + k + 1) p = k;
        end
        return p;
    endfunction

    // Codeword position of data bit j: non-power-of-two positions from 3 upwards.
    function automatic int dataPos(input int j);
        int pos;
        int n;
        pos = 0;
        n   = 0;
        for (int i = 3; i < 64; i++) begin
            if ((i & (i - 1)) != 0) begin
                if (n == j && pos == 0) pos = i;
                n++;
            end
        end
        return pos;
    endfunction

    localparam int P_W    = calcParityBits(DATA_W);
    localparam int CODE_W = DATA_W + P_W + 1;
    localparam int CB_W   = $clog2(CODE_W);
    localparam int WC_W   = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
    localparam int SH_W   = SYNC_W - 1;

    typedef enum logic {HUNT, RECV} state_t;

    state_t            state;
    logic [SH_W-1:0]   syncShift;
    logic [CODE_W-2:0] codeShift;
    logic [CB_W-1:0]   bitCnt;
    logic [WC_W-1:0]   wordCnt;

    // Decode of the word completed by the bit currently on serialIn.
    logic [CODE_W-1:0] codeWord;
    logic [CODE_W-1:0] fixedWord;
    logic [P_W-1:0]    syndrome;
    logic              parityOdd;
    logic              decCorr;
    logic              decDue;
    logic [DATA_W-1:0] decData;

    always_comb begin
        // codeShift holds positions CODE_W-1..1, serialIn is position 0.
        codeWord  = {codeShift, rx.serialIn};
        syndrome  = '0;
        for (int i = 1; i < CODE_W; i++) begin
            if (codeWord[i]) syndrome = syndrome ^ P_W'(i);
        end
        parityOdd = ^codeWord;
        fixedWord = codeWord;
        decCorr   = 1'b0;
        decDue    = 1'b0;
        if (parityOdd) begin
            if (syndrome == '0) begin
                // Only the overall parity bit is wrong; data is intact.
                decCorr = 1'b1;
            end else if (int'(syndrome) < CODE_W) begin
                for (int i = 1; i < CODE_W; i++) begin
                    if (syndrome == P_W'(i)) fixedWord[i] = ~codeWord[i];
                end
                decCorr = 1'b1;
            end else begin
                // Syndrome points past the codeword: cannot be a single error.
                decDue = 1'b1;
            end
        end else if (syndrome != '0) begin
            decDue = 1'b1;
        end
    end

    for (genvar j = 0; j < DATA_W; j++) begin : g_extract
        assign decData[j] = fixedWord[dataPos(j)];
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state            <= HUNT;
            syncShift        <= '0;
            codeShift        <= '0;
            bitCnt           <= '0;
            wordCnt          <= '0;
            rx.messageWord   <= '0;
            rx.isNew         <= 1'b0;
            rx.corrected     <= 1'b0;
            rx.uncorrectable <= 1'b0;
            rx.inFrame       <= 1'b0;
            corrCount        <= '0;
            dueCount         <= '0;
        end else begin
            rx.isNew <= 1'b0;
            case (state)
                HUNT: begin
                    if ({syncShift, rx.serialIn} == SYNC_PATTERN) begin
                        state      <= RECV;
                        rx.inFrame <= 1'b1;
                        // Cleared now so the next hunt starts from a blank history.
                        syncShift  <= '0;
                        bitCnt     <= '0;
                        wordCnt    <= '0;
                    end else begin
                        syncShift <= SH_W'({syncShift, rx.serialIn});
                    end
                end
                RECV: begin
                    codeShift <= (CODE_W-1)'({codeShift, rx.serialIn});
                    if (bitCnt == CB_W'(CODE_W - 1)) begin
                        rx.messageWord   <= decData;
                        rx.corrected     <= decCorr;
                        rx.uncorrectable <= decDue;
                        rx.isNew         <= 1'b1;
                        if (decCorr && corrCount != {CNT_W{1'b1}}) corrCount <= corrCount + 1'b1;
                        if (decDue && dueCount != {CNT_W{1'b1}}) dueCount <= dueCount + 1'b1;
                        bitCnt <= '0;
                        if (wordCnt == WC_W'(WORDS_PER_FRAME - 1) || (ABORT_ON_DUE && decDue)) begin
                            state      <= HUNT;
                            rx.inFrame <= 1'b0;
                            wordCnt    <= '0;
                        end else begin
                            wordCnt <= wordCnt + 1'b1;
                        end
                    end else begin
                        bitCnt <= bitCnt + 1'b1;
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_secded_receiver.sv
// tb/tb_serial_secded_receiver.sv - scoreboard bench for serial_secded_receiver (default and abort-on-DUE instances)
module tb_serial_secded_receiver;
    localparam logic [7:0] SYNC = 8'h7E;

    typedef struct {
        logic [7:0] data;
        logic       corr;
        logic       due;
    } exp_t;

    logic clock = 1'b0;
    logic reset_L = 1'b0;
    always #5 clock = ~clock;

    serial_secded_receiver_if #(.DATA_W(8)) rx0 ();
    serial_secded_receiver_if #(.DATA_W(8)) rx1 ();
    logic [7:0] corr0, due0, corr1, due1;

    serial_secded_receiver #(.ABORT_ON_DUE(1'b0)) dut0 (
        .clock(clock), .reset_L(reset_L), .rx(rx0.master), .corrCount(corr0), .dueCount(due0)
    );
    serial_secded_receiver #(.ABORT_ON_DUE(1'b1)) dut1 (
        .clock(clock), .reset_L(reset_L), .rx(rx1.master), .corrCount(corr1), .dueCount(due1)
    );

    int checks = 0;
    int errors = 0;
    exp_t q0[$];
    exp_t q1[$];
    int stamps0[$];
    int cyc = 0;
    int enters0 = 0;
    logic prevIn0 = 1'b0;
    int corrM = 0;
    int dueM = 0;

    task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference encoder: data at non-power-of-two positions, Hamming parity at 2^k, overall parity at 0.
    function automatic logic [12:0] encode(input logic [7:0] d);
        logic [12:0] cw;
        int n;
        cw = '0;
        n  = 0;
        for (int pos = 3; pos < 13; pos++) begin
            if (pos != 4 && pos != 8) begin
                cw[pos] = d[n];
                n++;
            end
        end
        for (int k = 0; k < 4; k++) begin
            logic p;
            p = 1'b0;
            for (int pos = 1; pos < 13; pos++) if (((pos >> k) & 1) == 1 && pos != (1 << k)) p = p ^ cw[pos];
            cw[1 << k] = p;
        end
        cw[0] = ^cw[12:1];
        return cw;
    endfunction

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (reset_L && rx0.isNew) begin
            stamps0.push_back(cyc);
            if (q0.size() == 0) begin
                checkVal("dut0 unexpected isNew", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                checkVal("dut0 messageWord", 32'(rx0.messageWord), 32'(e.data));
                checkVal("dut0 corrected", 32'(rx0.corrected), 32'(e.corr));
                checkVal("dut0 uncorrectable", 32'(rx0.uncorrectable), 32'(e.due));
            end
        end
        if (reset_L && rx1.isNew) begin
            if (q1.size() == 0) begin
                checkVal("dut1 unexpected isNew", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                checkVal("dut1 messageWord", 32'(rx1.messageWord), 32'(e.data));
                checkVal("dut1 corrected", 32'(rx1.corrected), 32'(e.corr));
                checkVal("dut1 uncorrectable", 32'(rx1.uncorrectable), 32'(e.due));
            end
        end
        if (rx0.inFrame && !prevIn0) enters0++;
        prevIn0 = rx0.inFrame;
    end

    task automatic sendBit(input int sel, input logic b);
        if (sel == 0) rx0.serialIn = b;
        else rx1.serialIn = b;
        @(posedge clock);
        #1;
    endtask

    task automatic sendSync(input int sel);
        for (int i = 7; i >= 0; i--) sendBit(sel, SYNC[i]);
    endtask

    task automatic sendWord(input int sel, input logic [12:0] cw, input logic [7:0] d,
                            input logic c, input logic u, input bit push);
        exp_t e;
        for (int i = 12; i >= 0; i--) sendBit(sel, cw[i]);
        if (push) begin
            e.data = d;
            e.corr = c;
            e.due  = u;
            if (sel == 0) begin
                q0.push_back(e);
                if (c && corrM < 255) corrM++;
                if (u && dueM < 255) dueM++;
            end else begin
                q1.push_back(e);
            end
        end
    endtask

    task automatic checkOutputsZero(input string tag);
        checkVal({tag, " messageWord"}, 32'(rx0.messageWord), 32'd0);
        checkVal({tag, " isNew"}, 32'(rx0.isNew), 32'd0);
        checkVal({tag, " corrected"}, 32'(rx0.corrected), 32'd0);
        checkVal({tag, " uncorrectable"}, 32'(rx0.uncorrectable), 32'd0);
        checkVal({tag, " inFrame"}, 32'(rx0.inFrame), 32'd0);
        checkVal({tag, " corrCount"}, 32'(corr0), 32'd0);
        checkVal({tag, " dueCount"}, 32'(due0), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic noise[10];
        int e0;
        noise = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        rx0.serialIn = 1'b0;
        rx1.serialIn = 1'b0;
        reset_L = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checkOutputsZero("reset");
        reset_L = 1'b1;
        sendBit(0, 1'b0);

        // Clean frame: four words, isNew 13 cycles apart, inFrame timing.
        stamps0.delete();
        sendSync(0);
        checkVal("inFrame after sync", 32'(rx0.inFrame), 32'd1);
        for (int w = 0; w < 4; w++) sendWord(0, encode(8'(8'h41 + w)), 8'(8'h41 + w), 1'b0, 1'b0, 1'b1);
        checkVal("inFrame after last word", 32'(rx0.inFrame), 32'd0);
        sendBit(0, 1'b0);
        sendBit(0, 1'b0);
        checkVal("clean isNew count", 32'(stamps0.size()), 32'd4);
        for (int i = 1; i < stamps0.size(); i++)
            checkVal("isNew spacing", 32'(stamps0[i] - stamps0[i-1]), 32'd13);
        checkVal("encode 0x41", 32'(encode(8'h41)), 32'h0909);

        // Single, parity-bit and double errors in one frame with ABORT_ON_DUE=0.
        sendSync(0);
        sendWord(0, 13'h0929, 8'h41, 1'b1, 1'b0, 1'b1);
        checkVal("single corrected flag", 32'(rx0.corrected), 32'd1);
        checkVal("single corrCount", 32'(corr0), 32'd1);
        sendWord(0, 13'h0908, 8'h41, 1'b1, 1'b0, 1'b1);
        sendWord(0, 13'h0969, 8'h47, 1'b0, 1'b1, 1'b1);
        checkVal("due continues frame", 32'(rx0.inFrame), 32'd1);
        checkVal("double dueCount", 32'(due0), 32'd1);
        sendWord(0, encode(8'h42), 8'h42, 1'b0, 1'b0, 1'b1);
        checkVal("corrCount after frame", 32'(corr0), 32'(corrM));
        checkVal("frame ended after 4", 32'(rx0.inFrame), 32'd0);

        // Noise then sync enters RECV once; 0x7C words carry 0111_1110 inside RECV.
        e0 = enters0;
        for (int i = 0; i < 10; i++) sendBit(0, noise[i]);
        checkVal("noise no frame", 32'(rx0.inFrame), 32'd0);
        sendSync(0);
        sendWord(0, encode(8'h7C), 8'h7C, 1'b0, 1'b0, 1'b1);
        sendWord(0, encode(8'h7C), 8'h7C, 1'b0, 1'b0, 1'b1);
        checkVal("no resync mid frame", 32'(rx0.inFrame), 32'd1);
        sendWord(0, encode(8'h7C), 8'h7C, 1'b0, 1'b0, 1'b1);
        sendWord(0, encode(8'h7C), 8'h7C, 1'b0, 1'b0, 1'b1);
        sendBit(0, 1'b0);
        checkVal("frame entries", 32'(enters0 - e0), 32'd1);

        // Reset at bit 6 of word 2.
        sendSync(0);
        sendWord(0, encode(8'h11), 8'h11, 1'b0, 1'b0, 1'b1);
        sendWord(0, encode(8'h22), 8'h22, 1'b0, 1'b0, 1'b1);
        begin
            logic [12:0] cw;
            cw = encode(8'h33);
            for (int i = 12; i > 6; i--) sendBit(0, cw[i]);
        end
        reset_L = 1'b0;
        #1;
        checkOutputsZero("midreset");
        corrM = 0;
        dueM = 0;
        repeat (2) @(posedge clock);
        #1;
        reset_L = 1'b1;
        sendBit(0, 1'b0);
        sendSync(0);
        for (int w = 0; w < 4; w++) sendWord(0, encode(8'(8'h51 + w)), 8'(8'h51 + w), 1'b0, 1'b0, 1'b1);
        sendBit(0, 1'b0);
        checkVal("post-reset queue drained", 32'(q0.size()), 32'd0);

        // Abort on DUE (dut1): word reported, HUNT next cycle, trailing bits ignored.
        sendBit(1, 1'b0);
        sendSync(1);
        sendWord(1, encode(8'h41), 8'h41, 1'b0, 1'b0, 1'b1);
        sendWord(1, 13'h0969, 8'h47, 1'b0, 1'b1, 1'b1);
        checkVal("abort inFrame", 32'(rx1.inFrame), 32'd0);
        checkVal("abort uncorrectable", 32'(rx1.uncorrectable), 32'd1);
        checkVal("abort dueCount", 32'(due1), 32'd1);
        sendWord(1, encode(8'h42), 8'h42, 1'b0, 1'b0, 1'b0);
        checkVal("ignored bits stay hunt", 32'(rx1.inFrame), 32'd0);
        sendSync(1);
        for (int w = 0; w < 4; w++) sendWord(1, encode(8'(8'h61 + w)), 8'(8'h61 + w), 1'b0, 1'b0, 1'b1);
        sendBit(1, 1'b0);
        checkVal("abort frames drained", 32'(q1.size()), 32'd0);

        // 300 double-error words: dueCount saturates.
        for (int f = 0; f < 75; f++) begin
            sendSync(0);
            for (int w = 0; w < 4; w++) sendWord(0, 13'h0969, 8'h47, 1'b0, 1'b1, 1'b1);
            if (f == 62) checkVal("dueCount at 252", 32'(due0), 32'd252);
        end
        checkVal("dueCount saturated", 32'(due0), 32'd255);
        checkVal("dueCount model", 32'(due0), 32'(dueM));
        checkVal("corrCount untouched", 32'(corr0), 32'd0);

        sendBit(0, 1'b0);
        sendBit(0, 1'b0);
        checkVal("dut0 queue empty", 32'(q0.size()), 32'd0);
        checkVal("dut1 queue empty", 32'(q1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
